gyro_loop_seq: RTL
==================

Name: gyro_loop_seq

Overview:
Sequencer for the gyro serial loopback datapath (DTX/DRX/DSYNC, TX pattern, RX bypass). It accepts start/abort/restart commands from the AXI register block, gates the TX and RX datapath enables, and waits for RX sync lock. It counts transmitted and received words against a programmed length and reports sticky status and an interrupt.

Parameters:
CNT_W, 16, width of word_count and the tx/rx counters
CLR_CYCLES, 4, number of cycles dp_clr is held asserted in FLUSH (>=1)
LOCK_TIMEOUT, 4096, cycles allowed in LOCK before lock-timeout error
DRAIN_TIMEOUT, 1024, cycles allowed in DRAIN before drain-timeout error
TMR_W, 16, timeout timer width (must hold max of both timeouts)

Ports:
ACLK  in  1  system clock
ARESET  in  1  reset, synchronous, active-high
start  in  1  single-cycle start; while busy it acts as restart
abort  in  1  single-cycle abort
loop_sel_in  in  2  loop mode 0=LOOP1, 1=LOOP2, 2=LOOP3, 3=reserved (treated as LOOP1)
rx_bypass  in  1  1 = skip sync lock phase
word_count  in  CNT_W  words to transfer, sampled on accepted start
sync_lock  in  1  RX sync detector locked (level)
tx_word_done  in  1  pulse per word sent by TX
rx_word_valid  in  1  pulse per word received by RX
status_clr  in  5  write-1-to-clear mask for status
dp_clr  out  1  datapath clear
tx_en  out  1  TX shifter enable
tx_pre  out  1  TX sends sync preamble instead of data
rx_en  out  1  RX enable
loop_sel  out  2  registered loop mode for the datapath mux
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on completion
tx_cnt  out  CNT_W  words sent in current run
rx_cnt  out  CNT_W  words received in current run
status  out  5  sticky [0]done [1]lock_to [2]drain_to [3]aborted [4]rx_overrun
irq  out  1  OR of status bits

Behaviour:
- Reset: state IDLE; all outputs 0; counters, timer, latched word_count and mode cleared.
- All outputs are registered. State transitions occur one cycle after the triggering input.
- States: IDLE, FLUSH, LOCK, RUN, DRAIN, DONE.
- IDLE: on start, latch word_count, loop_sel_in (3 maps to 0) and rx_bypass, clear tx_cnt and rx_cnt, then go to FLUSH.
- FLUSH: dp_clr=1 for exactly CLR_CYCLES cycles, all enables 0. Next state:
  - latched word_count==0 -> DONE;
  - rx_bypass=1 -> RUN;
  - otherwise -> LOCK.
  - If FLUSH was entered by abort, the next state is IDLE.
- LOCK: tx_en=1, tx_pre=1, rx_en=1, timer counts. On sync_lock=1, go to RUN. When the timer reaches LOCK_TIMEOUT-1 without lock, set status[1] and go to IDLE with all enables dropped.
- RUN: tx_en=1, tx_pre=0, rx_en=1.
  - Each tx_word_done increments tx_cnt.
  - When tx_cnt would reach word_count, go to DRAIN.
  - tx_word_done pulses beyond word_count are ignored.
- DRAIN: tx_en=0, rx_en=1, timer restarts from 0.
  - When rx_cnt==word_count, go to DONE.
  - When the timer reaches DRAIN_TIMEOUT-1 first, set status[2] and go to IDLE.
- DONE: done=1 for one cycle, set status[0], go to IDLE.
- rx_cnt increments on rx_word_valid in RUN and DRAIN, saturating at word_count. A pulse arriving while rx_cnt==word_count sets status[4].
- Abort in any non-IDLE state (including FLUSH restart): set status[3] and go to FLUSH(abort), then IDLE. Abort in IDLE is ignored.
- Start while busy (restart): same as a start from IDLE. It relatches inputs, clears counters, enters FLUSH and does not set aborted. Start and abort in the same cycle: abort wins.
- Sync_lock deasserting in RUN is not monitored; the datapath handles it.
- Status bits are sticky. status_clr bit=1 clears the corresponding bit. A set and a clear in the same cycle leave the bit set. irq is registered along with status.
- Counters hold their final values in IDLE until the next start.

Test Plan:
- Normal run: word_count=8, rx_bypass=0. sync_lock rises 10 cycles after LOCK entry; 8 tx_word_done and 8 rx_word_valid pulses. Expect dp_clr high for 4 cycles, tx_pre high only in LOCK, done pulse once, status=5'b00001, tx_cnt=rx_cnt=8, irq=1. status_clr=1 -> status=0, irq=0.
- RX bypass, LOOP3: loop_sel_in=2, rx_bypass=1, word_count=4. Expect FLUSH->RUN with no LOCK, tx_pre never 1, loop_sel=2, done after 4 rx words.
- Lock timeout: LOCK_TIMEOUT=16, sync_lock held 0. Expect status[1]=1 after 16 LOCK cycles, tx_en/rx_en=0, busy=0, no done pulse.
- Drain timeout plus overrun: run 1 has word_count=3 with only 2 rx words -> status[2] after DRAIN_TIMEOUT. Run 2 has word_count=2 with 3 rx words -> status[4]=1, rx_cnt=2.
- Restart and abort: start with word_count=16; after 5 tx words, assert start with word_count=6. Expect counters reset to 0, FLUSH re-entered, completion at 6 words, status[3]=0. Then start, abort on the same cycle as a second start in RUN -> status[3]=1, FLUSH then IDLE, no done.
- word_count=0 -> FLUSH(4 cycles) then done pulse, tx_en never asserted. ARESET mid-RUN -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/gyro_loop_seq.sv
// Sequencer for the gyro serial loopback datapath: flush, sync lock, run, drain, done.
// Latency: every output is registered and follows its triggering input by one cycle; no backpressure.
module gyro_loop_seq #(
    parameter int CNT_W         = 16,
    parameter int CLR_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int TMR_W         = 16
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       loop_sel_in,
    input  logic             rx_bypass,
    input  logic [CNT_W-1:0] word_count,
    input  logic             sync_lock,
    input  logic             tx_word_done,
    input  logic             rx_word_valid,
    input  logic [4:0]       status_clr,
    output logic             dp_clr,
    output logic             tx_en,
    output logic             tx_pre,
    output logic             rx_en,
    output logic [1:0]       loop_sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tx_cnt,
    output logic [CNT_W-1:0] rx_cnt,
    output logic [4:0]       status,
    output logic             irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_LOCK,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST   = CLR_W'(CLR_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] wc_q, wc_d;
    logic [1:0]       mode_q, mode_d;
    logic             byp_q, byp_d;
    logic             abrt_q, abrt_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [4:0]       status_q, status_d;
    logic [4:0]       status_set;
    logic [CNT_W-1:0] tx_inc;

    logic dp_clr_q, dp_clr_d;
    logic tx_en_q, tx_en_d;
    logic tx_pre_q, tx_pre_d;
    logic rx_en_q, rx_en_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic irq_q, irq_d;

    assign tx_inc = tx_cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        timer_d    = timer_q;
        wc_d       = wc_q;
        mode_d     = mode_q;
        byp_d      = byp_q;
        abrt_d     = abrt_q;
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        status_set = '0;

        // Abort outranks a simultaneous start; a start while busy is a full restart.
        if (abort && (state_q != S_IDLE)) begin
            state_d       = S_FLUSH;
            abrt_d        = 1'b1;
            clr_cnt_d     = '0;
            timer_d       = '0;
            status_set[3] = 1'b1;
        end else if (start) begin
            state_d   = S_FLUSH;
            abrt_d    = 1'b0;
            clr_cnt_d = '0;
            timer_d   = '0;
            wc_d      = word_count;
            mode_d    = (loop_sel_in == 2'd3) ? 2'd0 : loop_sel_in;
            byp_d     = rx_bypass;
            tx_cnt_d  = '0;
            rx_cnt_d  = '0;
        end else begin
            if (((state_q == S_RUN) || (state_q == S_DRAIN)) && rx_word_valid) begin
                if (rx_cnt_q == wc_q) begin
                    status_set[4] = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end

            case (state_q)
                S_FLUSH: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        timer_d = '0;
                        if (abrt_q) begin
                            state_d = S_IDLE;
                        end else if (wc_q == '0) begin
                            state_d = S_DONE;
                        end else if (byp_q) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_LOCK;
                        end
                    end else begin
                        clr_cnt_d = clr_cnt_q + CLR_W'(1);
                    end
                end
                S_LOCK: begin
                    if (sync_lock) begin
                        state_d = S_RUN;
                    end else if (timer_q == LOCK_LAST) begin
                        status_set[1] = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                S_RUN: begin
                    if (tx_word_done && (tx_cnt_q != wc_q)) begin
                        tx_cnt_d = tx_inc;
                        if (tx_inc == wc_q) begin
                            state_d = S_DRAIN;
                            timer_d = '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rx_cnt_q == wc_q) begin
                        state_d = S_DONE;
                    end else if (timer_q == DRAIN_LAST) begin
                        status_set[2] = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (state_d == S_DONE) begin
            status_set[0] = 1'b1;
        end

        // A set in the same cycle as its clear leaves the bit set.
        status_d = (status_q & ~status_clr) | status_set;
        irq_d    = |status_d;

        dp_clr_d = (state_d == S_FLUSH);
        tx_en_d  = (state_d == S_LOCK) || (state_d == S_RUN);
        tx_pre_d = (state_d == S_LOCK);
        rx_en_d  = (state_d == S_LOCK) || (state_d == S_RUN) || (state_d == S_DRAIN);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            clr_cnt_q <= '0;
            timer_q   <= '0;
            wc_q      <= '0;
            mode_q    <= '0;
            byp_q     <= 1'b0;
            abrt_q    <= 1'b0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            status_q  <= '0;
            irq_q     <= 1'b0;
            dp_clr_q  <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_pre_q  <= 1'b0;
            rx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            timer_q   <= timer_d;
            wc_q      <= wc_d;
            mode_q    <= mode_d;
            byp_q     <= byp_d;
            abrt_q    <= abrt_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            status_q  <= status_d;
            irq_q     <= irq_d;
            dp_clr_q  <= dp_clr_d;
            tx_en_q   <= tx_en_d;
            tx_pre_q  <= tx_pre_d;
            rx_en_q   <= rx_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign dp_clr   = dp_clr_q;
    assign tx_en    = tx_en_q;
    assign tx_pre   = tx_pre_q;
    assign rx_en    = rx_en_q;
    assign loop_sel = mode_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tx_cnt   = tx_cnt_q;
    assign rx_cnt   = rx_cnt_q;
    assign status   = status_q;
    assign irq      = irq_q;

endmodule
